// File: rtl/apuracao_tx.sv
// Tally report transmitter: snapshots the three vote counters on a rising edge of finish and
// sends HEADER, C1, C2, Null (plus a checksum byte when APURACAO_CHECKSUM_EN is defined) as 8N1 UART.
`timescale 1ns/1ps
module apuracao_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       finish,
  input  logic [7:0] contadorC1,
  input  logic [7:0] contadorC2,
  input  logic [7:0] contadorNull,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
`ifdef APURACAO_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          finish_q;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    c1_q, c1_d, c2_q, c2_d, cn_q, cn_d;
  logic          done_q, done_d;
  logic          trigger, bit_end;
  logic [2:0]    next_idx;
  logic [7:0]    next_byte;

  assign trigger  = finish & ~finish_q;
  assign bit_end  = (clk_cnt_q == CNT_MAX);
  assign next_idx = byte_idx_q + 3'd1;

  always_comb begin
    next_byte = HEADER;
    case (next_idx)
      3'd1: next_byte = c1_q;
      3'd2: next_byte = c2_q;
      3'd3: next_byte = cn_q;
`ifdef APURACAO_CHECKSUM_EN
      // 8-bit addition is exactly the low byte of the full 10-bit sum
      3'd4: next_byte = c1_q + c2_q + cn_q;
`endif
      default: next_byte = HEADER;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    cn_d       = cn_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (trigger) begin
          c1_d       = contadorC1;
          c2_d       = contadorC2;
          cn_d       = contadorNull;
          shreg_d    = HEADER;
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (byte_idx_q == LAST_BYTE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            // back-to-back frames: next start bit follows the stop bit directly
            byte_idx_d = next_idx;
            shreg_d    = next_byte;
            state_d    = S_START;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      finish_q   <= 1'b0;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      cn_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      finish_q   <= finish;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      cn_q       <= cn_d;
      done_q     <= done_d;
    end
  end

  // Decoded straight from state so reset forces the line high without waiting for a clock
  assign tx   = (state_q == S_START) ? 1'b0 :
                (state_q == S_DATA)  ? shreg_q[0] : 1'b1;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_apuracao_tx.sv
// Directed bench for apuracao_tx: decodes UART frames from tx and checks bytes, busy/done timing.
`timescale 1ns/1ps
module tb_apuracao_tx;

  localparam int CPB = 4;
`ifdef APURACAO_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       finish = 1'b0;
  logic [7:0] contadorC1 = 8'd0;
  logic [7:0] contadorC2 = 8'd0;
  logic [7:0] contadorNull = 8'd0;
  logic       tx, busy, done;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_bytes [0:4];

  apuracao_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .finish(finish),
    .contadorC1(contadorC1), .contadorC2(contadorC2), .contadorNull(contadorNull),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] cn,
                         input logic [7:0] cs);
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = c1;
    exp_bytes[2] = c2;
    exp_bytes[3] = cn;
    exp_bytes[4] = cs;
  endtask

  // Call at the negedge just before the triggering posedge; each loop pass is one frame cycle.
  task automatic check_frame(input string tag);
    logic [7:0] got;
    int busy_cnt, done_cnt;
    logic framing_ok;
    busy_cnt = 0;
    done_cnt = 0;
    framing_ok = 1'b1;
    for (int b = 0; b < NB; b++) begin
      got = '0;
      for (int bi = 0; bi < 10; bi++) begin
        for (int c = 0; c < CPB; c++) begin
          @(negedge clk);
          if (busy === 1'b1) busy_cnt++;
          if (done === 1'b1) done_cnt++;
          if (c == CPB / 2) begin
            if (bi == 0) begin
              if (tx !== 1'b0) framing_ok = 1'b0;
            end else if (bi == 9) begin
              if (tx !== 1'b1) framing_ok = 1'b0;
            end else begin
              got[bi-1] = tx;
            end
          end
        end
      end
      chk($sformatf("%s_byte%0d", tag, b), {24'd0, got}, {24'd0, exp_bytes[b]});
    end
    chk({tag, "_framing"}, {31'd0, framing_ok}, 32'd1);
    chk({tag, "_busy_cycles"}, busy_cnt, NB * 10 * CPB);
    chk({tag, "_early_done"}, done_cnt, 0);
    @(negedge clk);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    chk({tag, "_tx_end"}, {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Idle line for 500 cycles
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt_a++;
      if (busy !== 1'b0) cnt_b++;
      if (done !== 1'b0) cnt_c++;
    end
    chk("idle_tx", cnt_a, 0);
    chk("idle_busy", cnt_b, 0);
    chk("idle_done", cnt_c, 0);

    // Basic report 12/6/1, checksum 0x13
    contadorC1 = 8'd12; contadorC2 = 8'd6; contadorNull = 8'd1;
    set_exp(8'h0C, 8'h06, 8'h01, 8'h13);
    finish = 1'b1;
    check_frame("basic");
    finish = 1'b0;
    @(negedge clk);

    // Checksum wrap 200+100+0 = 300 -> 0x2C
    contadorC1 = 8'd200; contadorC2 = 8'd100; contadorNull = 8'd0;
    set_exp(8'hC8, 8'h64, 8'h00, 8'h2C);
    finish = 1'b1;
    check_frame("wrap");
    finish = 1'b0;
    @(negedge clk);

    // Snapshot isolation and ignored retrigger mid-frame
    contadorC1 = 8'd3; contadorC2 = 8'd4; contadorNull = 8'd5;
    set_exp(8'h03, 8'h04, 8'h05, 8'h0C);
    finish = 1'b1;
    fork
      check_frame("snap");
      begin
        repeat (50) @(negedge clk);
        contadorC1 = 8'd9;
        finish = 1'b0;
        @(negedge clk);
        finish = 1'b1;
      end
    join
    cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt_b++;
    end
    chk("snap_no_second_frame", cnt_b, 0);
    finish = 1'b0;
    @(negedge clk);

    // Held finish: one report only, second after a fresh edge
    contadorC1 = 8'd7; contadorC2 = 8'd8; contadorNull = 8'd9;
    set_exp(8'h07, 8'h08, 8'h09, 8'h18);
    finish = 1'b1;
    check_frame("held1");
    cnt_b = 0;
    for (int i = 0; i < 1000 - (NB * 10 * CPB + 2); i++) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt_b++;
    end
    chk("held_no_retrigger", cnt_b, 0);
    finish = 1'b0;
    @(negedge clk);
    finish = 1'b1;
    check_frame("held2");
    finish = 1'b0;
    @(negedge clk);

    // Reset during DATA of byte 2, then restart with finish still high
    contadorC1 = 8'd1; contadorC2 = 8'd2; contadorNull = 8'd3;
    set_exp(8'h01, 8'h02, 8'h03, 8'h06);
    finish = 1'b1;
    repeat (90) @(negedge clk);
    chk("prereset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", {31'd0, tx}, 32'd1);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    cnt_c = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) cnt_c++;
    end
    chk("rst_no_done", cnt_c, 0);
    rst_n = 1'b1;
    check_frame("after_rst");
    finish = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apuracao_tx.md
# apuracao_tx

Tally report transmitter for the electronic ballot box. It sits at the output end of the vote-counting block and reads the three 8-bit vote counters (candidate 1, candidate 2, null) when voting is closed by `finish`. It snapshots those counters and sends them out as one framed report over a single-wire UART line (8N1, LSB first) to the results terminal. It is the reader/transmitter for the counters that the ballot box writes.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit. Legal range 2–65535.
- `HEADER`, default 8'hA5: first byte of every report.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `finish`  in  1  end-of-voting level from the ballot box. A rising edge requests one report.
- `contadorC1`  in  8  candidate 1 vote count.
- `contadorC2`  in  8  candidate 2 vote count.
- `contadorNull`  in  8  null vote count.
- `tx`  out  1  UART serial line. Idles high.
- `busy`  out  1  high while a report is being sent.
- `done`  out  1  one-cycle pulse when a report completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0. Internal state: FSM=IDLE, `finish_q`=0, all counters and shift register cleared.
- Edge detect: the trigger is `finish & ~finish_q`, with `finish_q` registered every cycle.
- `finish_q` resets to 0. If `finish` is held high through reset release, a report fires on the first cycle after reset.
- FSM states:
  - IDLE → START on trigger. On that edge, snapshot C1, C2 and Null into internal registers and set the byte index to 0.
  - START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles → STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. If more bytes remain, → START with no idle gap. Otherwise → IDLE and pulse `done`.
- Byte order: `HEADER`, C1, C2, Null, then the checksum byte when enabled (see Configuration).
- Snapshot isolation: changes on the counter inputs while `busy`=1 have no effect on the report in progress.
- A trigger that arrives while `busy`=1 is ignored: it is neither queued nor restarts the report. A new report needs `finish` to fall and rise again after `busy` drops.
- Reset mid-report: `tx` goes to 1 immediately (asynchronously), `busy`=0, no `done` pulse, and the partial frame is abandoned.

## Timing
- Trigger at clock edge N (`finish`=1 and `finish_q`=0 sampled):
  - `busy` and `tx`=0 (start bit) are visible after edge N.
  - Bit k of the frame occupies cycles N+k·CLKS_PER_BIT through N+(k+1)·CLKS_PER_BIT−1.
- Frame length is B·10·CLKS_PER_BIT cycles, where B = 5 with the checksum and B = 4 without.
- At edge N+B·10·CLKS_PER_BIT, `busy` falls and `done`=1 for exactly one cycle. `tx` stays at 1.
- The earliest next trigger is the cycle after `busy` falls, and only if `finish` has been low for at least one sampled cycle in between.
- The bit counter is width ⌈log2(CLKS_PER_BIT)⌉ and counts 0..CLKS_PER_BIT−1. It never wraps mid-bit.

## Configuration
- Macro `APURACAO_CHECKSUM_EN`.
- Defined: a fifth byte is sent, equal to (C1+C2+Null) mod 256 computed on the snapshot values. The sum is 10 bits wide, truncated to 8. B=5.
- Undefined: no checksum logic is built and the frame is 4 bytes. B=4.

## Test plan
- Basic report (checksum on, CLKS_PER_BIT=4): C1=12, C2=6, Null=1, then `finish` 0→1. Expected bytes on `tx`: A5 0C 06 01 13. `busy` high for 200 cycles, then a single `done` pulse.
- Checksum wrap: C1=200, C2=100, Null=0. Checksum byte is 0x2C. With the macro undefined, exactly 4 bytes and 160 busy cycles.
- Snapshot isolation and ignored retrigger: start a report with C1=3. Mid-frame, change C1 to 9 and pulse `finish` low then high. The report still carries 03, and no second frame follows.
- Held `finish`: keep `finish` high for 1000 cycles. Exactly one report is sent. Drop and re-raise `finish` after `done`, and a second report is sent.
- Reset mid-frame: assert `rst_n`=0 during the DATA state of byte 2. `tx`=1 and `busy`=0 immediately, with no `done`. After release with `finish` still high, a full new report starts on the next cycle.
- Idle line: with `finish`=0 throughout, `tx` stays 1 and `busy`/`done` stay 0 for 500 cycles.
